// File: rtl/fpu_mul_param.sv
// Parametrised multi-cycle floating-point multiplier with round-to-nearest-even,
// flush-to-zero subnormals, exception flags and a four-wire ready/ack handshake.
module fpu_mul_param #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [EXP_W+MAN_W:0]   data_a,
   input  logic [EXP_W+MAN_W:0]   data_b,
   input  logic                   input_rdy,
   output logic                   input_ack,
   output logic                   output_rdy,
   input  logic                   output_ack,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);
   localparam int DATA_W = 1 + EXP_W + MAN_W;
   localparam int M      = MAN_W + 1;
   localparam int PW     = 2 * M;
   localparam int XW     = EXP_W + 2;
   localparam int CW     = $clog2(M);
   localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] ONE_X  = XW'(1);
   localparam logic signed [XW-1:0] ZERO_X = XW'(0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_UNPACK = 3'd1;
   localparam logic [2:0] S_MUL    = 3'd2;
   localparam logic [2:0] S_NORM   = 3'd3;
   localparam logic [2:0] S_ROUND  = 3'd4;
   localparam logic [2:0] S_PACK   = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   logic [2:0]              state_q,   state_d;
   logic [DATA_W-1:0]       opa_q,     opa_d;
   logic [DATA_W-1:0]       opb_q,     opb_d;
   logic                    sign_q,    sign_d;
   logic signed [XW-1:0]    exp_q,     exp_d;
   logic [M-1:0]            ma_q,      ma_d;
   logic [M-1:0]            mb_q,      mb_d;
   logic [PW-1:0]           prod_q,    prod_d;
   logic [CW-1:0]           cnt_q,     cnt_d;
   logic [MAN_W-1:0]        man_q,     man_d;
   logic                    guard_q,   guard_d;
   logic                    sticky_q,  sticky_d;
   logic                    inexact_q, inexact_d;
   logic                    special_q, special_d;
   logic [DATA_W-1:0]       spres_q,   spres_d;
   logic [3:0]              spflg_q,   spflg_d;
   logic [DATA_W-1:0]       result_q,  result_d;
   logic [3:0]              flags_q,   flags_d;
   logic                    iack_q,    iack_d;
   logic                    ordy_q,    ordy_d;

   logic                    sa_s, sb_s;
   logic [EXP_W-1:0]        ea_s, eb_s;
   logic [MAN_W-1:0]        fa_s, fb_s;
   logic                    nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
   logic signed [XW-1:0]    exp_sum_s;
   logic [PW-1:0]           addend_s;
   logic [PW-1:0]           norm_s;
   logic                    round_inc_s;
   logic [MAN_W:0]          rnd_sum_s;

   assign sa_s     = opa_q[DATA_W-1];
   assign sb_s     = opb_q[DATA_W-1];
   assign ea_s     = opa_q[DATA_W-2 -: EXP_W];
   assign eb_s     = opb_q[DATA_W-2 -: EXP_W];
   assign fa_s     = opa_q[MAN_W-1:0];
   assign fb_s     = opb_q[MAN_W-1:0];
   assign nan_a_s  = (&ea_s) && (fa_s != {MAN_W{1'b0}});
   assign nan_b_s  = (&eb_s) && (fb_s != {MAN_W{1'b0}});
   assign inf_a_s  = (&ea_s) && (fa_s == {MAN_W{1'b0}});
   assign inf_b_s  = (&eb_s) && (fb_s == {MAN_W{1'b0}});
   assign zero_a_s = (ea_s == {EXP_W{1'b0}});
   assign zero_b_s = (eb_s == {EXP_W{1'b0}});
   assign exp_sum_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_X;
   assign addend_s  = {{M{1'b0}}, ma_q} << cnt_q;
   // Product lies in [1,4): left-align so the hidden bit always sits at PW-1 without dropping bits.
   assign norm_s      = prod_q[PW-1] ? prod_q : (prod_q << 1);
   assign round_inc_s = guard_q & (sticky_q | man_q[0]);
   assign rnd_sum_s   = {1'b0, man_q} + {{MAN_W{1'b0}}, round_inc_s};

   // Next-state and datapath control for the multiply sequence.
   always_comb begin
      state_d   = state_q;   opa_d     = opa_q;     opb_d    = opb_q;
      sign_d    = sign_q;    exp_d     = exp_q;     ma_d     = ma_q;
      mb_d      = mb_q;      prod_d    = prod_q;    cnt_d    = cnt_q;
      man_d     = man_q;     guard_d   = guard_q;   sticky_d = sticky_q;
      inexact_d = inexact_q; special_d = special_q; spres_d  = spres_q;
      spflg_d   = spflg_q;   result_d  = result_q;  flags_d  = flags_q;
      iack_d    = iack_q;    ordy_d    = ordy_q;
      case (state_q)
         S_IDLE: begin
            if (input_rdy) begin
               opa_d   = data_a;
               opb_d   = data_b;
               iack_d  = 1'b1;
               state_d = S_UNPACK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_UNPACK: begin
            sign_d    = sa_s ^ sb_s;
            ma_d      = {1'b1, fa_s};
            mb_d      = {1'b1, fb_s};
            prod_d    = {PW{1'b0}};
            cnt_d     = {CW{1'b0}};
            special_d = 1'b1;
            spflg_d   = 4'b0000;
            state_d   = S_PACK;
            if (nan_a_s || nan_b_s || (inf_a_s && zero_b_s) || (inf_b_s && zero_a_s)) begin
               spres_d = {DATA_W{1'b1}};
               spflg_d = 4'b1000;
            end else if (inf_a_s || inf_b_s) begin
               spres_d = {sa_s ^ sb_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (zero_a_s || zero_b_s) begin
               spres_d = {sa_s ^ sb_s, {(DATA_W-1){1'b0}}};
            end else begin
               special_d = 1'b0;
               exp_d     = exp_sum_s;
               state_d   = S_MUL;
            end
         end
         S_MUL: begin
            if (mb_q[cnt_q]) begin
               prod_d = prod_q + addend_s;
            end else begin
               prod_d = prod_q;
            end
            if (cnt_q == CW'(M - 1)) begin
               state_d = S_NORM;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_NORM: begin
            if (prod_q[PW-1]) begin
               exp_d = exp_q + ONE_X;
            end else begin
               exp_d = exp_q;
            end
            man_d    = norm_s[PW-2 -: MAN_W];
            guard_d  = norm_s[M-1];
            sticky_d = |norm_s[M-2:0];
            state_d  = S_ROUND;
         end
         S_ROUND: begin
            if (rnd_sum_s[MAN_W]) begin
               man_d = {MAN_W{1'b0}};
               exp_d = exp_q + ONE_X;
            end else begin
               man_d = rnd_sum_s[MAN_W-1:0];
            end
            inexact_d = guard_q | sticky_q;
            state_d   = S_PACK;
         end
         S_PACK: begin
            ordy_d  = 1'b1;
            state_d = S_DONE;
            if (special_q) begin
               result_d = spres_q;
               flags_d  = spflg_q;
            end else if (exp_q >= EMAX_X) begin
               result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags_d  = 4'b0101;
            end else if (exp_q <= ZERO_X) begin
               result_d = {sign_q, {(DATA_W-1){1'b0}}};
               flags_d  = 4'b0011;
            end else begin
               result_d = {sign_q, exp_q[EXP_W-1:0], man_q};
               flags_d  = {3'b000, inexact_q};
            end
         end
         S_DONE: begin
            if (output_ack) begin
               ordy_d  = 1'b0;
               iack_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any operation in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;              opa_q     <= {DATA_W{1'b0}};
         opb_q     <= {DATA_W{1'b0}};      sign_q    <= 1'b0;
         exp_q     <= ZERO_X;              ma_q      <= {M{1'b0}};
         mb_q      <= {M{1'b0}};           prod_q    <= {PW{1'b0}};
         cnt_q     <= {CW{1'b0}};          man_q     <= {MAN_W{1'b0}};
         guard_q   <= 1'b0;                sticky_q  <= 1'b0;
         inexact_q <= 1'b0;                special_q <= 1'b0;
         spres_q   <= {DATA_W{1'b0}};      spflg_q   <= 4'b0000;
         result_q  <= {DATA_W{1'b0}};      flags_q   <= 4'b0000;
         iack_q    <= 1'b0;                ordy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;             opa_q     <= opa_d;
         opb_q     <= opb_d;               sign_q    <= sign_d;
         exp_q     <= exp_d;               ma_q      <= ma_d;
         mb_q      <= mb_d;                prod_q    <= prod_d;
         cnt_q     <= cnt_d;               man_q     <= man_d;
         guard_q   <= guard_d;             sticky_q  <= sticky_d;
         inexact_q <= inexact_d;           special_q <= special_d;
         spres_q   <= spres_d;             spflg_q   <= spflg_d;
         result_q  <= result_d;            flags_q   <= flags_d;
         iack_q    <= iack_d;              ordy_q    <= ordy_d;
      end
   end

   assign input_ack  = iack_q;
   assign output_rdy = ordy_q;
   assign result     = result_q;
   assign flags      = flags_q;
endmodule

// File: tb/tb_fpu_mul_param.sv
// Bench for fpu_mul_param: directed plan cases plus random operands checked
// against an integer-arithmetic reference model, on binary32 and 5/10 instances.
module tb_fpu_mul_param;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] a32 = 32'h0, b32 = 32'h0, res32;
   logic        rdy32 = 1'b0, iack32, ordy32, oack32 = 1'b0;
   logic [3:0]  fl32;
   logic [15:0] a16 = 16'h0, b16 = 16'h0, res16;
   logic        rdy16 = 1'b0, iack16, ordy16, oack16 = 1'b0;
   logic [3:0]  fl16;
   logic        sel = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   fpu_mul_param #(.EXP_W(8), .MAN_W(23)) dut32 (
      .clock(clk), .reset(reset), .data_a(a32), .data_b(b32),
      .input_rdy(rdy32), .input_ack(iack32), .output_rdy(ordy32),
      .output_ack(oack32), .result(res32), .flags(fl32));

   fpu_mul_param #(.EXP_W(5), .MAN_W(10)) dut16 (
      .clock(clk), .reset(reset), .data_a(a16), .data_b(b16),
      .input_rdy(rdy16), .input_ack(iack16), .output_rdy(ordy16),
      .output_ack(oack16), .result(res16), .flags(fl16));

   wire        ordy_m = sel ? ordy16 : ordy32;
   wire        iack_m = sel ? iack16 : iack32;
   wire [31:0] res_m  = sel ? {16'h0, res16} : res32;
   wire [3:0]  fl_m   = sel ? fl16 : fl32;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer product, rounded by comparing the remainder against one half.
   task automatic ref_mul(input int ew, input int mw, input longint unsigned a, input longint unsigned b,
                          output longint unsigned res, output logic [3:0] fl, output bit spec);
      longint unsigned emax, fmask, ea, eb, fa, fb, sa, sb, s, prod, q, rem, half;
      longint e, bias;
      int sh;
      bit nan_a, nan_b, inf_a, inf_b, z_a, z_b, inexact;
      emax  = (64'd1 << ew) - 1;
      fmask = (64'd1 << mw) - 1;
      bias  = (64'd1 << (ew - 1)) - 1;
      sa = (a >> (ew + mw)) & 1;  sb = (b >> (ew + mw)) & 1;
      ea = (a >> mw) & emax;      eb = (b >> mw) & emax;
      fa = a & fmask;             fb = b & fmask;
      s  = sa ^ sb;
      nan_a = (ea == emax) && (fa != 0);  nan_b = (eb == emax) && (fb != 0);
      inf_a = (ea == emax) && (fa == 0);  inf_b = (eb == emax) && (fb == 0);
      z_a = (ea == 0);  z_b = (eb == 0);
      spec = 1'b1;
      fl = 4'b0000;
      if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) begin
         res = (64'd1 << (1 + ew + mw)) - 1;
         fl  = 4'b1000;
      end else if (inf_a || inf_b) begin
         res = (s << (ew + mw)) | (emax << mw);
      end else if (z_a || z_b) begin
         res = s << (ew + mw);
      end else begin
         spec = 1'b0;
         prod = (fa | (64'd1 << mw)) * (fb | (64'd1 << mw));
         e    = longint'(ea) + longint'(eb) - bias;
         sh   = mw;
         if (prod >= (64'd1 << (2 * mw + 1))) begin
            sh = mw + 1;
            e  = e + 1;
         end
         q    = prod >> sh;
         rem  = prod & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         inexact = (rem != 0);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (64'd1 << (mw + 1))) begin
            q = q >> 1;
            e = e + 1;
         end
         if (e >= longint'(emax)) begin
            res = (s << (ew + mw)) | (emax << mw);
            fl  = 4'b0101;
         end else if (e <= 0) begin
            res = s << (ew + mw);
            fl  = 4'b0011;
         end else begin
            res = (s << (ew + mw)) | (longint'(e) << mw) | (q & fmask);
            fl  = {3'b000, inexact};
         end
      end
   endtask

   task automatic do_op(input string tag, input bit sel_i, input logic [31:0] a, input logic [31:0] b,
                        input bit use_lit, input logic [31:0] lit_res, input logic [3:0] lit_fl,
                        input int hold);
      longint unsigned mres;
      logic [3:0]      mfl, exp_fl;
      logic [31:0]     exp_res;
      bit              mspec;
      int              mw, lat, lat_exp;
      mw = sel_i ? 10 : 23;
      ref_mul(sel_i ? 5 : 8, mw, 64'(a), 64'(b), mres, mfl, mspec);
      exp_res = use_lit ? lit_res : mres[31:0];
      exp_fl  = use_lit ? lit_fl : mfl;
      lat_exp = mspec ? 2 : mw + 5;
      @(negedge clk);
      sel = sel_i;
      if (sel_i) begin
         a16 = a[15:0]; b16 = b[15:0]; rdy16 = 1'b1;
      end else begin
         a32 = a; b32 = b; rdy32 = 1'b1;
      end
      @(posedge clk);
      #1;
      rdy16 = 1'b0; rdy32 = 1'b0;
      check({tag, ".iack"}, 64'(iack_m), 64'd1);
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         lat++;
         #1;
         if (ordy_m) break;
      end
      check({tag, ".lat"}, 64'(lat), 64'(lat_exp));
      check({tag, ".res"}, 64'(res_m), 64'(exp_res));
      check({tag, ".flags"}, 64'(fl_m), 64'(exp_fl));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, ".hold_res"}, 64'(res_m), 64'(exp_res));
         check({tag, ".hold_rdy"}, 64'(ordy_m), 64'd1);
      end
      if (sel_i) oack16 = 1'b1; else oack32 = 1'b1;
      @(posedge clk);
      #1;
      oack16 = 1'b0; oack32 = 1'b0;
      check({tag, ".rdy_clr"}, 64'(ordy_m), 64'd0);
      check({tag, ".iack_clr"}, 64'(iack_m), 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      #1;
      check("rst.iack", 64'(iack32), 64'd0);
      check("rst.ordy", 64'(ordy32), 64'd0);
      check("rst.res",  64'(res32),  64'd0);
      check("rst.flags", 64'(fl32),  64'd0);
      @(negedge clk);
      reset = 1'b1;

      do_op("two_sq",   1'b0, 32'h40000000, 32'h40000000, 1'b1, 32'h40800000, 4'b0000, 0);
      do_op("neg_two",  1'b0, 32'hC0000000, 32'h40000000, 1'b1, 32'hC0800000, 4'b0000, 0);
      do_op("rne_up",   1'b0, 32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 4'b0001, 0);
      do_op("one5_sq",  1'b0, 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40100000, 4'b0000, 0);
      do_op("nan",      1'b0, 32'h7FC00000, 32'h3F800000, 1'b1, 32'hFFFFFFFF, 4'b1000, 0);
      do_op("inf_zero", 1'b0, 32'h7F800000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'b1000, 0);
      do_op("ninf",     1'b0, 32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 4'b0000, 0);
      do_op("ovf",      1'b0, 32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F800000, 4'b0101, 0);
      do_op("unf",      1'b0, 32'h00800000, 32'h3F000000, 1'b1, 32'h00000000, 4'b0011, 0);
      do_op("subn",     1'b0, 32'h00000001, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 0);
      do_op("hold",     1'b0, 32'h40400000, 32'h40400000, 1'b1, 32'h41100000, 4'b0000, 10);

      // Abort in the middle of the shift-add loop.
      @(negedge clk);
      sel = 1'b0; a32 = 32'h40000000; b32 = 32'h40000000; rdy32 = 1'b1;
      @(posedge clk);
      #1;
      rdy32 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("abort.iack",  64'(iack32), 64'd0);
      check("abort.ordy",  64'(ordy32), 64'd0);
      check("abort.res",   64'(res32),  64'd0);
      check("abort.flags", 64'(fl32),   64'd0);
      @(negedge clk);
      reset = 1'b1;
      do_op("after_rst", 1'b0, 32'h40000000, 32'h40000000, 1'b1, 32'h40800000, 4'b0000, 0);

      do_op("h_2x3", 1'b1, 32'h4000, 32'h4200, 1'b1, 32'h4600, 4'b0000, 0);
      do_op("h_ovf", 1'b1, 32'h7BFF, 32'h4000, 1'b1, 32'h7C00, 4'b0101, 0);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 != 0) begin
            ra[30:23] = 8'($urandom_range(60, 190));
            rb[30:23] = 8'($urandom_range(60, 190));
         end
         do_op("rnd32", 1'b0, ra, rb, 1'b0, 32'h0, 4'b0000, 0);
      end
      for (int i = 0; i < 40; i++) begin
         ra = {16'h0, 16'($urandom)};
         rb = {16'h0, 16'($urandom)};
         do_op("rnd16", 1'b1, ra, rb, 1'b0, 32'h0, 4'b0000, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
